// File: rtl/tlu_pkg.sv
// Shared state type, mode encodings and helpers for the TLU DUT output stage.
package tlu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIG_HI,
        SHIFT,
        WAIT_LOW
    } tlu_state_e;

    localparam logic        TLU_MODE_TRIG        = 1'b0;
    localparam logic        TLU_MODE_DATA        = 1'b1;
    localparam logic [15:0] TLU_DEFAULT_TIME_OUT = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/tlu_sync_edge.sv
// Two-flop synchroniser for an asynchronous DUT line, with single-cycle rise/fall pulses.
module tlu_sync_edge (
    input  logic SYS_CLK,
    input  logic SYS_RST_N,
    input  logic IN_ASYNC,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= IN_ASYNC;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign LEVEL = sync_q;
    assign RISE  = sync_q & ~prev_q;
    assign FALL  = ~sync_q & prev_q;

endmodule

// File: rtl/tlu_dut_handshake.sv
// Per-DUT trigger/busy handshake with optional LSB-first trigger-ID readout on the trigger line.
// Define TLU_HANDSHAKE_CNT_EN to build the completed-handshake counter on HANDSHAKE_CNT.
module tlu_dut_handshake
    import tlu_pkg::*;
#(
    parameter int unsigned ID_WIDTH      = 15,
    parameter bit          INV_OUT       = 1'b0,
    parameter int unsigned RST_PULSE_LEN = 8
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RST_N,
    input  logic                ENABLE,
    input  logic                CONF_DATA_MODE,
    input  logic [15:0]         CONF_TIME_OUT,
    input  logic                TRIG,
    input  logic [ID_WIDTH-1:0] TRIG_ID,
    input  logic                RST_REQ,
    output logic                READY,
    output logic                TIME_OUT,
    output logic [15:0]         HANDSHAKE_CNT,
    input  logic                TLU_CLOCK,
    input  logic                TLU_BUSY,
    output logic                TLU_TRIGGER,
    output logic                TLU_RESET
);

    localparam int unsigned IDX_W = $clog2(ID_WIDTH + 1);
    localparam int unsigned RST_W = $clog2(RST_PULSE_LEN + 1);

    tlu_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         to_cnt_q, to_cnt_d;
    logic                trig_q, trig_d;
    logic                time_out_q, time_out_d;
    logic                ready_q;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic                rst_q;
    logic                to_hit;
    logic                hs_done;

    logic busy_level, busy_rise, busy_fall;
    logic clk_level, clk_rise, clk_fall;
    logic unused_sig;

    tlu_sync_edge u_sync_busy (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST_N (SYS_RST_N),
        .IN_ASYNC  (TLU_BUSY),
        .LEVEL     (busy_level),
        .RISE      (busy_rise),
        .FALL      (busy_fall)
    );

    tlu_sync_edge u_sync_clk (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST_N (SYS_RST_N),
        .IN_ASYNC  (TLU_CLOCK),
        .LEVEL     (clk_level),
        .RISE      (clk_rise),
        .FALL      (clk_fall)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        idx_d      = idx_q;
        trig_d     = trig_q;
        time_out_d = 1'b0;
        hs_done    = 1'b0;
        to_cnt_d   = (state_q == IDLE) ? to_cnt_q : sat_inc16(to_cnt_q);
        to_hit     = (state_q != IDLE) && (CONF_TIME_OUT != 16'd0) &&
                     (to_cnt_q == CONF_TIME_OUT - 16'd1);

        unique case (state_q)
            IDLE: begin
                if (TRIG && ENABLE) begin
                    id_d     = TRIG_ID;
                    to_cnt_d = '0;
                    trig_d   = 1'b1;
                    state_d  = TRIG_HI;
                end
            end
            TRIG_HI: begin
                trig_d = 1'b1;
                if (busy_level) begin
                    trig_d  = 1'b0;
                    idx_d   = '0;
                    state_d = (CONF_DATA_MODE == TLU_MODE_DATA) ? SHIFT : WAIT_LOW;
                end
            end
            SHIFT: begin
                if (busy_fall) begin
                    trig_d  = 1'b0;
                    hs_done = 1'b1;
                    state_d = IDLE;
                end else if (clk_rise) begin
                    // Shifting zeros in makes surplus clock rises drive 0.
                    trig_d = id_q[0];
                    id_d   = id_q >> 1;
                    if (idx_q != IDX_W'(ID_WIDTH)) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (clk_fall && (idx_q == IDX_W'(ID_WIDTH))) begin
                    trig_d  = 1'b0;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!busy_level) begin
                    hs_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (to_hit) begin
            trig_d     = 1'b0;
            time_out_d = 1'b1;
            hs_done    = 1'b0;
            state_d    = IDLE;
        end
    end

    always_comb begin
        if (RST_REQ) begin
            rst_cnt_d = RST_W'(RST_PULSE_LEN);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
        end else begin
            rst_cnt_d = rst_cnt_q;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            state_q    <= IDLE;
            id_q       <= '0;
            idx_q      <= '0;
            to_cnt_q   <= '0;
            trig_q     <= 1'b0;
            time_out_q <= 1'b0;
            ready_q    <= ENABLE;
            rst_cnt_q  <= '0;
            rst_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
            trig_q     <= trig_d;
            time_out_q <= time_out_d;
            ready_q    <= !ENABLE || (state_d == IDLE);
            rst_cnt_q  <= rst_cnt_d;
            rst_q      <= (rst_cnt_d != '0);
        end
    end

`ifdef TLU_HANDSHAKE_CNT_EN
    logic [15:0] hs_cnt_q;

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            hs_cnt_q <= '0;
        end else if (hs_done) begin
            hs_cnt_q <= hs_cnt_q + 16'd1;
        end
    end

    assign HANDSHAKE_CNT = hs_cnt_q;
    assign unused_sig    = busy_rise ^ clk_level;
`else
    assign HANDSHAKE_CNT = '0;
    assign unused_sig    = busy_rise ^ clk_level ^ hs_done;
`endif

    assign READY       = ready_q;
    assign TIME_OUT    = time_out_q;
    assign TLU_TRIGGER = trig_q ^ INV_OUT;
    assign TLU_RESET   = rst_q ^ INV_OUT;

endmodule

// File: tb/tb_tlu_dut_handshake.sv
// Directed bench for tlu_dut_handshake: normal/inverted pad instances driven by shared inputs.
module tb_tlu_dut_handshake;
    import tlu_pkg::*;

`ifdef TLU_HANDSHAKE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        sys_clk;
    logic        sys_rst_n;
    logic        enable;
    logic        conf_data_mode;
    logic [15:0] conf_time_out;
    logic        trig;
    logic [14:0] trig_id;
    logic        rst_req;
    logic        tlu_clock;
    logic        tlu_busy;

    logic        ready, time_out, tlu_trigger, tlu_reset;
    logic [15:0] hs_cnt;
    logic        ready_n, time_out_n, tlu_trigger_n, tlu_reset_n;
    logic [15:0] hs_cnt_n;

    int errors;
    int checks;
    int hs_exp;
    bit seen;
    int exp_bits [15] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1};

    tlu_dut_handshake #(.ID_WIDTH(15), .INV_OUT(1'b0), .RST_PULSE_LEN(8)) u_dut (
        .SYS_CLK        (sys_clk),
        .SYS_RST_N      (sys_rst_n),
        .ENABLE         (enable),
        .CONF_DATA_MODE (conf_data_mode),
        .CONF_TIME_OUT  (conf_time_out),
        .TRIG           (trig),
        .TRIG_ID        (trig_id),
        .RST_REQ        (rst_req),
        .READY          (ready),
        .TIME_OUT       (time_out),
        .HANDSHAKE_CNT  (hs_cnt),
        .TLU_CLOCK      (tlu_clock),
        .TLU_BUSY       (tlu_busy),
        .TLU_TRIGGER    (tlu_trigger),
        .TLU_RESET      (tlu_reset)
    );

    tlu_dut_handshake #(.ID_WIDTH(15), .INV_OUT(1'b1), .RST_PULSE_LEN(8)) u_dut_inv (
        .SYS_CLK        (sys_clk),
        .SYS_RST_N      (sys_rst_n),
        .ENABLE         (enable),
        .CONF_DATA_MODE (conf_data_mode),
        .CONF_TIME_OUT  (conf_time_out),
        .TRIG           (trig),
        .TRIG_ID        (trig_id),
        .RST_REQ        (rst_req),
        .READY          (ready_n),
        .TIME_OUT       (time_out_n),
        .HANDSHAKE_CNT  (hs_cnt_n),
        .TLU_CLOCK      (tlu_clock),
        .TLU_BUSY       (tlu_busy),
        .TLU_TRIGGER    (tlu_trigger_n),
        .TLU_RESET      (tlu_reset_n)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_trig(input logic [14:0] id);
        trig    = 1'b1;
        trig_id = id;
        tick(1);
        trig    = 1'b0;
    endtask

    function automatic int cnt_exp(input int n);
        return CNT_EN ? (n & 16'hFFFF) : 0;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        hs_exp = 0;
        sys_rst_n      = 1'b0;
        enable         = 1'b1;
        conf_data_mode = TLU_MODE_TRIG;
        conf_time_out  = TLU_DEFAULT_TIME_OUT;
        trig           = 1'b0;
        trig_id        = '0;
        rst_req        = 1'b0;
        tlu_clock      = 1'b0;
        tlu_busy       = 1'b0;

        // Reset state
        tick(2);
        check("rst_ready", ready, 1);
        check("rst_time_out", time_out, 0);
        check("rst_hs_cnt", hs_cnt, 0);
        check("rst_trigger", tlu_trigger, 0);
        check("rst_reset", tlu_reset, 0);
        check("rst_trigger_inv", tlu_trigger_n, 1);
        check("rst_reset_inv", tlu_reset_n, 1);
        check("rst_ready_inv", ready_n, 1);
        sys_rst_n = 1'b1;
        tick(1);

        // Mode 0 handshake: busy up 10 cycles after TRIG, down 30 later
        pulse_trig(15'h1234);
        check("m0_trig_hi", tlu_trigger, 1);
        check("m0_ready_lo", ready, 0);
        tick(9);
        tlu_busy = 1'b1;
        tick(2);
        check("m0_trig_busy2", tlu_trigger, 1);
        tick(1);
        check("m0_trig_busy3", tlu_trigger, 0);
        check("m0_ready_wait", ready, 0);
        tick(27);
        tlu_busy = 1'b0;
        tick(2);
        check("m0_ready_fall2", ready, 0);
        tick(1);
        hs_exp++;
        check("m0_ready_fall3", ready, 1);
        check("m0_hs_cnt", hs_cnt, cnt_exp(hs_exp));
        check("m0_no_timeout", time_out, 0);

        // Mode 1: ID 0x5A3C shifted LSB first over 15 DUT clock pulses
        conf_data_mode = TLU_MODE_DATA;
        pulse_trig(15'h5A3C);
        tlu_busy = 1'b1;
        tick(3);
        check("m1_shift_entry", tlu_trigger, 0);
        for (int i = 0; i < 15; i++) begin
            tlu_clock = 1'b1;
            tick(2);
            tlu_clock = 1'b0;
            tick(1);
            check($sformatf("m1_bit%0d", i), tlu_trigger, exp_bits[i]);
            tick(1);
        end
        tick(1);
        check("m1_line_low", tlu_trigger, 0);
        check("m1_ready_lo", ready, 0);
        tlu_busy = 1'b0;
        tick(3);
        hs_exp++;
        check("m1_ready", ready, 1);
        check("m1_hs_cnt", hs_cnt, cnt_exp(hs_exp));

        // Timeout of 100 with busy never asserted
        conf_data_mode = TLU_MODE_TRIG;
        conf_time_out  = 16'd100;
        pulse_trig(15'h0001);
        tick(99);
        check("to_pre", time_out, 0);
        check("to_pre_ready", ready, 0);
        tick(1);
        check("to_pulse", time_out, 1);
        check("to_trig_low", tlu_trigger, 0);
        tick(1);
        check("to_single", time_out, 0);
        check("to_ready", ready, 1);
        check("to_hs_cnt", hs_cnt, cnt_exp(hs_exp));

        // Busy stuck high: timeout, then a data-mode retrigger advances at once
        conf_time_out = 16'd20;
        tlu_busy = 1'b1;
        tick(3);
        pulse_trig(15'h0000);
        check("stuck_trig_hi", tlu_trigger, 1);
        tick(1);
        check("stuck_adv", tlu_trigger, 0);
        check("stuck_ready", ready, 0);
        pulse_trig(15'h7FFF);
        tick(17);
        check("stuck_to_pre", time_out, 0);
        tick(1);
        check("stuck_to", time_out, 1);
        check("stuck_ready_after", ready, 1);
        conf_data_mode = TLU_MODE_DATA;
        pulse_trig(15'h0003);
        check("stuck2_trig_hi", tlu_trigger, 1);
        tick(1);
        check("stuck2_adv", tlu_trigger, 0);
        pulse_trig(15'h0000);
        check("stuck2_ignored_ready", ready, 0);
        tlu_clock = 1'b1;
        tick(2);
        tlu_clock = 1'b0;
        tick(1);
        check("stuck2_latched_bit0", tlu_trigger, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (time_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("stuck2_timeout_seen", seen, 1);
        check("stuck2_hs_cnt", hs_cnt, cnt_exp(hs_exp));

        // TLU_RESET: two requests 3 cycles apart, channel disabled
        tlu_busy = 1'b0;
        enable   = 1'b0;
        tick(3);
        pulse_trig(15'h0001);
        check("dis_ready", ready, 1);
        check("dis_trig_ignored", tlu_trigger, 0);
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        check("rr_first", tlu_reset, 1);
        check("rr_first_inv", tlu_reset_n, 0);
        tick(2);
        rst_req = 1'b1;
        tick(1);
        rst_req = 1'b0;
        tick(7);
        check("rr_cycle11", tlu_reset, 1);
        tick(1);
        check("rr_cycle12", tlu_reset, 0);
        check("rr_idle_inv", tlu_reset_n, 1);
        check("rr_trig_idle_inv", tlu_trigger_n, 1);

        // Synchronous reset in the middle of SHIFT
        enable        = 1'b1;
        conf_time_out = TLU_DEFAULT_TIME_OUT;
        pulse_trig(15'h0001);
        tlu_busy = 1'b1;
        tick(3);
        tlu_clock = 1'b1;
        tick(2);
        tlu_clock = 1'b0;
        tick(1);
        check("sr_pre_bit", tlu_trigger, 1);
        check("sr_pre_cnt", hs_cnt, cnt_exp(hs_exp));
        sys_rst_n = 1'b0;
        tick(1);
        check("sr_trigger", tlu_trigger, 0);
        check("sr_trigger_inv", tlu_trigger_n, 1);
        check("sr_time_out", time_out, 0);
        check("sr_hs_cnt", hs_cnt, 0);
        check("sr_hs_cnt_inv", hs_cnt_n, 0);
        sys_rst_n = 1'b1;
        tlu_busy  = 1'b0;
        tick(1);
        check("sr_ready", ready, 1);
        check("sr_no_timeout", time_out_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
